// File: rtl/ysyx_22050518_wb_pkg.sv
// Writeback unit package: datapath widths, load size encodings and grant encoding.
package ysyx_22050518_wb_pkg;

  localparam int XLEN   = 64;
  localparam int NREG   = 32;
  localparam int REG_AW = $clog2(NREG);

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_LSU = 1'b1
  } grant_e;

  // One-hot mask selecting a single architectural register.
  function automatic logic [NREG-1:0] reg_onehot(input logic [REG_AW-1:0] addr);
    return {{(NREG-1){1'b0}}, 1'b1} << addr;
  endfunction

endpackage

// File: rtl/ysyx_22050518_load_ext.sv
// Load extension: selects the low byte/half/word of right-aligned load data and
// sign- or zero-extends it to XLEN; doublewords pass through untouched.
module ysyx_22050518_load_ext
  import ysyx_22050518_wb_pkg::*;
(
  input  logic [XLEN-1:0] i_rdata,
  input  logic [1:0]      i_size,
  input  logic            i_unsigned,
  output logic [XLEN-1:0] o_data
);

  logic w_sign_b;
  logic w_sign_h;
  logic w_sign_w;

  assign w_sign_b = i_rdata[7]  & ~i_unsigned;
  assign w_sign_h = i_rdata[15] & ~i_unsigned;
  assign w_sign_w = i_rdata[31] & ~i_unsigned;

  // Pick the access width and fill the upper bits with the extension bit.
  always_comb begin
    o_data = i_rdata;
    case (i_size)
      SZ_B:    o_data = {{(XLEN-8){w_sign_b}},  i_rdata[7:0]};
      SZ_H:    o_data = {{(XLEN-16){w_sign_h}}, i_rdata[15:0]};
      SZ_W:    o_data = {{(XLEN-32){w_sign_w}}, i_rdata[31:0]};
      SZ_D:    o_data = i_rdata;
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/ysyx_22050518_wb_unit.sv
// Writeback unit: arbitrates ALU and LSU results onto the register-file write
// port (one registered write per cycle), tracks pending destinations for issue
// hazard checks and counts accepted writebacks.
// Optional feature: define YSYX_22050518_WB_BYPASS_EN to release busy and
// forward rd in the cycle the matching write is presented.
module ysyx_22050518_wb_unit
  import ysyx_22050518_wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_AW-1:0] alu_rd_addr,
  input  logic [XLEN-1:0]   alu_result,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [REG_AW-1:0] lsu_rd_addr,
  input  logic [XLEN-1:0]   lsu_rdata,
  input  logic [1:0]        lsu_size,
  input  logic              lsu_unsigned,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_rd_addr,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              write_en,
  output logic [REG_AW-1:0] rd_addr,
  output logic [XLEN-1:0]   rd,
`ifdef YSYX_22050518_WB_BYPASS_EN
  output logic [XLEN-1:0]   rs1_fwd,
  output logic [XLEN-1:0]   rs2_fwd,
`endif
  output logic [63:0]       retire_cnt
);

  grant_e            r_last_grant;
  logic              r_write_en;
  logic [REG_AW-1:0] r_rd_addr;
  logic [XLEN-1:0]   r_rd;
  logic [63:0]       r_retire_cnt;
  logic [NREG-1:0]   r_pending;

  logic              w_alu_gnt;
  logic              w_lsu_gnt;
  logic              w_acc;
  logic [REG_AW-1:0] w_acc_addr;
  logic [XLEN-1:0]   w_acc_data;
  logic [XLEN-1:0]   w_load_data;
  logic [NREG-1:0]   w_set_mask;
  logic [NREG-1:0]   w_clr_mask;

  ysyx_22050518_load_ext u_load_ext (
    .i_rdata    (lsu_rdata),
    .i_size     (lsu_size),
    .i_unsigned (lsu_unsigned),
    .o_data     (w_load_data)
  );

  // Arbitration: a lone requester wins; under contention the source not granted last time wins.
  always_comb begin
    w_alu_gnt = 1'b0;
    w_lsu_gnt = 1'b0;
    if (!rst_n) begin
      w_alu_gnt = 1'b0;
      w_lsu_gnt = 1'b0;
    end else if (alu_valid && lsu_valid) begin
      w_alu_gnt = (r_last_grant == GNT_LSU);
      w_lsu_gnt = (r_last_grant == GNT_ALU);
    end else begin
      w_alu_gnt = alu_valid;
      w_lsu_gnt = lsu_valid;
    end
  end

  assign alu_ready = w_alu_gnt;
  assign lsu_ready = w_lsu_gnt;
  assign w_acc     = w_alu_gnt | w_lsu_gnt;

  // Select the destination and data of whichever source was granted.
  always_comb begin
    w_acc_addr = {REG_AW{1'b0}};
    w_acc_data = {XLEN{1'b0}};
    if (w_alu_gnt) begin
      w_acc_addr = alu_rd_addr;
      w_acc_data = alu_result;
    end else if (w_lsu_gnt) begin
      w_acc_addr = lsu_rd_addr;
      w_acc_data = w_load_data;
    end else begin
      w_acc_addr = {REG_AW{1'b0}};
      w_acc_data = {XLEN{1'b0}};
    end
  end

  // Scoreboard masks: issue marks a destination, the presented write releases one.
  always_comb begin
    w_set_mask = {NREG{1'b0}};
    w_clr_mask = {NREG{1'b0}};
    if (iss_valid && (iss_rd_addr != {REG_AW{1'b0}})) begin
      w_set_mask = reg_onehot(iss_rd_addr);
    end else begin
      w_set_mask = {NREG{1'b0}};
    end
    if (r_write_en) begin
      w_clr_mask = reg_onehot(r_rd_addr);
    end else begin
      w_clr_mask = {NREG{1'b0}};
    end
  end

  // Output stage: register the accepted result; writes to x0 complete without a strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_write_en   <= 1'b0;
      r_rd_addr    <= {REG_AW{1'b0}};
      r_rd         <= {XLEN{1'b0}};
      r_last_grant <= GNT_ALU;
    end else if (w_acc) begin
      r_write_en   <= (w_acc_addr != {REG_AW{1'b0}});
      r_rd_addr    <= w_acc_addr;
      r_rd         <= w_acc_data;
      r_last_grant <= w_alu_gnt ? GNT_ALU : GNT_LSU;
    end else begin
      r_write_en   <= 1'b0;
    end
  end

  // Retire counter: one per accepted handshake, wrapping naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_retire_cnt <= 64'd0;
    end else if (w_acc) begin
      r_retire_cnt <= r_retire_cnt + 64'd1;
    end
  end

  // Pending scoreboard: a new issue to the same register outranks the clearing write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending <= {NREG{1'b0}};
    end else begin
      r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
    end
  end

  assign write_en   = r_write_en;
  assign rd_addr    = r_rd_addr;
  assign rd         = r_rd;
  assign retire_cnt = r_retire_cnt;

`ifdef YSYX_22050518_WB_BYPASS_EN
  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit = r_write_en && (r_rd_addr == rs1_addr);
  assign w_rs2_hit = r_write_en && (r_rd_addr == rs2_addr);
  assign rs1_busy  = r_pending[rs1_addr] && (rs1_addr != {REG_AW{1'b0}}) && !w_rs1_hit;
  assign rs2_busy  = r_pending[rs2_addr] && (rs2_addr != {REG_AW{1'b0}}) && !w_rs2_hit;
  assign rs1_fwd   = w_rs1_hit ? r_rd : {XLEN{1'b0}};
  assign rs2_fwd   = w_rs2_hit ? r_rd : {XLEN{1'b0}};
`else
  assign rs1_busy  = r_pending[rs1_addr] && (rs1_addr != {REG_AW{1'b0}});
  assign rs2_busy  = r_pending[rs2_addr] && (rs2_addr != {REG_AW{1'b0}});
`endif

endmodule
